// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared sizes and state type for the imem sequencer
package imem_pkg;

    localparam int IMEM_DEPTH = 60;
    localparam int IMEM_AW    = 6;
    localparam int IMEM_DW    = 9;

    typedef enum logic [1:0] {
        LOAD,
        FULL,
        READ,
        DRAIN
    } imem_state_t;

endpackage

// File: rtl/imem_addr_cnt.sv
// rtl/imem_addr_cnt.sv - wrapping address counter with clear, enable and terminal flag
//
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   clr            : synchronous clear to 0 (wins over en)
//   en             : advance; wraps to 0 after DEPTH-1
//   cnt            : current address
//   last           : cnt == DEPTH-1
module imem_addr_cnt #(
    parameter int DEPTH = 60,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == AW'(DEPTH - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - fill/read-pass sequencer owning every imem port signal
//
// Ports:
//   clock, reset_n              : clock, asynchronous active-low reset
//   in_valid/in_data/in_ready   : input word stream (accepted only while loading)
//   start, keep                 : request one read pass; keep=1 retains the buffer
//   flush                       : synchronous abort back to an empty buffer
//   full                        : buffer holds DEPTH words and is idle
//   out_valid/out_data/out_last : read words, aligned with the memory's 1-cycle latency
//   done                        : pass-complete pulse, coincident with out_last
//   mem_*                       : imem write port (iaddr/idata/wr), read port (oaddr/rd/odata)
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW,
    parameter int DW    = IMEM_DW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          start,
    input  logic          keep,
    input  logic          flush,
    output logic          full,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          done,
    output logic [AW-1:0] mem_iaddr,
    output logic [DW-1:0] mem_idata,
    output logic          mem_wr,
    output logic [AW-1:0] mem_oaddr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_odata
);

    imem_state_t   state, state_nx;
    logic          keep_r;
    logic [AW-1:0] wcnt, rcnt;
    logic          w_last, r_last;
    logic          w_en, w_clr, r_en, r_clr;

    imem_addr_cnt #(.DEPTH(DEPTH), .AW(AW)) u_wcnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (w_clr),
        .en      (w_en),
        .cnt     (wcnt),
        .last    (w_last)
    );

    imem_addr_cnt #(.DEPTH(DEPTH), .AW(AW)) u_rcnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (r_clr),
        .en      (r_en),
        .cnt     (rcnt),
        .last    (r_last)
    );

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        full     = 1'b0;
        mem_wr   = 1'b0;
        mem_rd   = 1'b0;
        w_en     = 1'b0;
        w_clr    = 1'b0;
        r_en     = 1'b0;
        r_clr    = 1'b0;

        case (state)
            LOAD: begin
                in_ready = 1'b1;
                mem_wr   = in_valid;
                w_en     = in_valid;
                // The write counter wraps to 0 by itself on the final word.
                if (in_valid && w_last) begin
                    state_nx = FULL;
                end
            end
            FULL: begin
                full = 1'b1;
                if (start) begin
                    state_nx = READ;
                    r_clr    = 1'b1;
                end
            end
            READ: begin
                mem_rd = 1'b1;
                r_en   = 1'b1;
                if (r_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = keep_r ? FULL : LOAD;
            end
            default: begin
                state_nx = LOAD;
            end
        endcase

        // Abort overrides everything: no memory access and no handshake this cycle.
        if (flush) begin
            state_nx = LOAD;
            in_ready = 1'b0;
            mem_wr   = 1'b0;
            mem_rd   = 1'b0;
            w_en     = 1'b0;
            r_en     = 1'b0;
            w_clr    = 1'b1;
            r_clr    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD;
            keep_r    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == FULL && start && !flush) begin
                keep_r <= keep;
            end
            // mem_rd is already forced low during flush, so the in-flight word is dropped.
            out_valid <= mem_rd;
            out_last  <= mem_rd && r_last;
        end
    end

    assign done      = out_last;
    assign out_data  = mem_odata;
    assign mem_iaddr = wcnt;
    assign mem_idata = in_data;
    assign mem_oaddr = rcnt;

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - self-checking bench for imem_ctrl with a behavioural imem
module tb_imem_ctrl;

    localparam int DEPTH = 60;
    localparam int AW    = 6;
    localparam int DW    = 9;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          start;
    logic          keep;
    logic          flush;
    logic          full;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic [AW-1:0] mem_iaddr;
    logic [DW-1:0] mem_idata;
    logic          mem_wr;
    logic [AW-1:0] mem_oaddr;
    logic          mem_rd;
    logic [DW-1:0] mem_odata;

    imem_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .keep      (keep),
        .flush     (flush),
        .full      (full),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .mem_iaddr (mem_iaddr),
        .mem_idata (mem_idata),
        .mem_wr    (mem_wr),
        .mem_oaddr (mem_oaddr),
        .mem_rd    (mem_rd),
        .mem_odata (mem_odata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural imem: synchronous write, registered read.
    logic [DW-1:0] mem [0:DEPTH-1];
    initial mem_odata = '0;
    always @(posedge clock) begin
        if (mem_wr) mem[mem_iaddr] <= mem_idata;
        if (mem_rd) mem_odata <= mem[mem_oaddr];
    end

    int conflicts = 0;
    always @(negedge clock) begin
        if (mem_wr && mem_rd) conflicts++;
    end

    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0] exp_words [0:DEPTH-1];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        start    = 1'b0;
        keep     = 1'b0;
        flush    = 1'b0;
    endtask

    // mode 0: one word per cycle; 1: idle cycle before every word; 2: random gaps and data.
    // With gaps, a start pulse is injected in an idle cycle before word 31 (must be ignored).
    task automatic fill(input int base, input int mode, input int n);
        for (int k = 0; k < n; k++) begin
            int idle;
            idle = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (mode != 0 && k == 31 && idle == 0) idle = 1;
            for (int i = 0; i < idle; i++) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom_range(0, 511));
                start    = (k == 31 && i == 0);
                @(negedge clock);
                check("fill_idle_wr", mem_wr, 0);
                check("fill_idle_rd", mem_rd, 0);
                next_cyc();
            end
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = (mode == 2) ? DW'($urandom_range(0, 511)) : DW'(base + k);
            exp_words[k] = in_data;
            @(negedge clock);
            check("fill_rdy", in_ready, 1);
            check("fill_wr", mem_wr, 1);
            check("fill_iaddr", mem_iaddr, k);
            check("fill_idata", mem_idata, exp_words[k]);
            next_cyc();
        end
        in_valid = 1'b0;
        if (n == DEPTH) begin
            @(negedge clock);
            check("full_set", full, 1);
            check("full_rdy", in_ready, 0);
            next_cyc();
        end
    endtask

    // Start at cycle 0; cycle c of the pass is checked against the expected timeline.
    task automatic run_pass(input bit keep_i, input bit noise);
        start = 1'b1;
        keep  = keep_i;
        @(negedge clock);
        check("pass_full", full, 1);
        next_cyc();
        start = 1'b0;
        keep  = 1'b0;
        for (int c = 1; c <= DEPTH + 2; c++) begin
            if (noise && c <= DEPTH + 1) begin
                start    = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                in_data  = DW'($urandom_range(0, 511));
            end else begin
                start    = 1'b0;
                in_valid = 1'b0;
            end
            @(negedge clock);
            check("pass_rd", mem_rd, int'(c <= DEPTH));
            check("pass_wr", mem_wr, 0);
            if (c <= DEPTH) check("pass_oaddr", mem_oaddr, c - 1);
            check("pass_ov", out_valid, int'(c >= 2 && c <= DEPTH + 1));
            if (c >= 2 && c <= DEPTH + 1) check("pass_od", out_data, exp_words[c - 2]);
            check("pass_last", out_last, int'(c == DEPTH + 1));
            check("pass_done", done, int'(c == DEPTH + 1));
            if (c == DEPTH + 2) begin
                check("post_rdy", in_ready, int'(!keep_i));
                check("post_full", full, int'(keep_i));
            end
            next_cyc();
        end
        idle_inputs();
    endtask

    task automatic flush_cycle();
        flush = 1'b1;
        @(negedge clock);
        check("flush_wr", mem_wr, 0);
        check("flush_rd", mem_rd, 0);
        next_cyc();
        flush = 1'b0;
        @(negedge clock);
        check("flush_rdy", in_ready, 1);
        check("flush_full", full, 0);
        next_cyc();
    endtask

    // Assert reset away from the edge and check outputs before any clock edge.
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check({tag, "_ov"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_wr"}, mem_wr, 0);
        check({tag, "_rd"}, mem_rd, 0);
        check({tag, "_iaddr"}, mem_iaddr, 0);
        check({tag, "_oaddr"}, mem_oaddr, 0);
        check({tag, "_rdy"}, in_ready, 1);
        idle_inputs();
        next_cyc();
        reset_n = 1'b1;
        next_cyc();
    endtask

    typedef struct {
        bit       iv;
        bit [8:0] d;
        bit       st;
        bit       fl;
        bit       e_rdy;
        bit       e_wr;
        int       e_iaddr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{iv: 0, d: 9'd0,  st: 0, fl: 0, e_rdy: 1, e_wr: 0, e_iaddr: 0};
        vecs[1] = '{iv: 1, d: 9'd5,  st: 0, fl: 1, e_rdy: 0, e_wr: 0, e_iaddr: 0};
        vecs[2] = '{iv: 1, d: 9'd7,  st: 0, fl: 0, e_rdy: 1, e_wr: 1, e_iaddr: 0};
        vecs[3] = '{iv: 1, d: 9'd9,  st: 1, fl: 0, e_rdy: 1, e_wr: 1, e_iaddr: 1};
        vecs[4] = '{iv: 0, d: 9'd11, st: 0, fl: 0, e_rdy: 1, e_wr: 0, e_iaddr: 2};
        vecs[5] = '{iv: 1, d: 9'd13, st: 0, fl: 1, e_rdy: 0, e_wr: 0, e_iaddr: 2};
        vecs[6] = '{iv: 1, d: 9'd15, st: 0, fl: 0, e_rdy: 1, e_wr: 1, e_iaddr: 0};
        vecs[7] = '{iv: 0, d: 9'd17, st: 0, fl: 1, e_rdy: 0, e_wr: 0, e_iaddr: 1};

        reset_n = 1'b0;
        in_data = '0;
        idle_inputs();
        #1;
        check("rst_rdy", in_ready, 1);
        check("rst_full", full, 0);
        check("rst_ov", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_iaddr", mem_iaddr, 0);
        check("rst_oaddr", mem_oaddr, 0);
        next_cyc();
        next_cyc();
        reset_n = 1'b1;

        // Single-cycle LOAD behaviour incl. flush priority and ignored start.
        for (int i = 0; i < 8; i++) begin
            in_valid = vecs[i].iv;
            in_data  = vecs[i].d;
            start    = vecs[i].st;
            flush    = vecs[i].fl;
            @(negedge clock);
            check("vec_rdy", in_ready, int'(vecs[i].e_rdy));
            check("vec_wr", mem_wr, int'(vecs[i].e_wr));
            check("vec_iaddr", mem_iaddr, vecs[i].e_iaddr);
            check("vec_rd", mem_rd, 0);
            check("vec_full", full, 0);
            next_cyc();
        end
        idle_inputs();

        // Back-to-back fill 0..59, non-keep pass.
        fill(0, 0, DEPTH);
        run_pass(1'b0, 1'b0);

        // Gapped fill 100..159, noisy start/in_valid during the pass.
        fill(100, 1, DEPTH);
        run_pass(1'b0, 1'b1);

        // Keep: two identical passes, second start two cycles after done.
        fill(200, 0, DEPTH);
        run_pass(1'b1, 1'b0);
        run_pass(1'b1, 1'b1);
        flush_cycle();

        // Flush at read address 20.
        fill(300, 0, DEPTH);
        start = 1'b1;
        @(negedge clock);
        next_cyc();
        start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            flush = (c == 21);
            @(negedge clock);
            if (c <= 20) begin
                check("fl_rd", mem_rd, 1);
                check("fl_oaddr", mem_oaddr, c - 1);
            end else begin
                check("fl_rd_off", mem_rd, 0);
            end
            if (c == 21) begin
                check("fl_ov_tail", out_valid, 1);
                check("fl_od_tail", out_data, exp_words[19]);
            end
            if (c >= 22) begin
                check("fl_ov_off", out_valid, 0);
                check("fl_done_off", done, 0);
                check("fl_rdy", in_ready, 1);
            end
            next_cyc();
        end
        idle_inputs();
        fill(320, 0, DEPTH);
        run_pass(1'b0, 1'b0);

        // Reset mid-fill at word 10, then refill.
        fill(400, 0, 10);
        async_reset("rstfill");
        fill(0, 0, DEPTH);
        run_pass(1'b0, 1'b0);

        // Reset mid-pass.
        fill(50, 0, DEPTH);
        start = 1'b1;
        @(negedge clock);
        next_cyc();
        start = 1'b0;
        for (int c = 1; c < 30; c++) next_cyc();
        async_reset("rstpass");
        fill(0, 0, DEPTH);
        run_pass(1'b0, 1'b0);

        // Randomized fills, delays and keep against the reference word array.
        for (int r = 0; r < 4; r++) begin
            bit k;
            int wait_n;
            k = 1'($urandom_range(0, 1));
            wait_n = int'($urandom_range(0, 3));
            fill(0, 2, DEPTH);
            for (int w = 0; w < wait_n; w++) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom_range(0, 511));
                @(negedge clock);
                check("rnd_hold_full", full, 1);
                check("rnd_hold_wr", mem_wr, 0);
                next_cyc();
            end
            idle_inputs();
            run_pass(k, 1'b1);
            if (k) begin
                run_pass(1'b1, 1'b1);
                flush_cycle();
            end
        end

        check("no_wr_rd_overlap", conflicts, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
